rx_demux: RTL and testbench

RX_DEMUX -- requirements
Module: rx_demux

---
 rtl/rx_demux.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_rx_demux.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_demux.sv
`default_nettype none
// ============================================================================
// Module      : rx_demux
// Description : Receive-side symbol demultiplexer. Classifies each incoming
//               byte (data or control symbol), acquires symbol lock on the
//               first COM, frames TLP/DLLP packets between STP/SDP and
//               END/EDB, strips skip ordered sets, and reports payload bytes,
//               packet events, framing errors and saturating statistics.
//               Every output is registered: a byte sampled at edge N is
//               reflected on the outputs right after edge N.
// Ports       : clk, rst (sync, active-high), enb (clock enable)
//               rx_multiplexada[7:0] / rx_ValidS : incoming byte / 1 = data
//               rx_DataS[7:0], rx_data_valid     : payload byte stream
//               symbol_code[3:0]                 : class of last byte
//               locked                           : symbol lock achieved
//               pkt_start/pkt_end/pkt_abort/err_framing : 1-cycle pulses
//               pkt_len[10:0]                    : length of last packet
//               skp_cnt[7:0], err_cnt[7:0]       : saturating counters
// Revision    : 1.0 - initial release
// ============================================================================
module rx_demux #(
    parameter logic [7:0] COM    = 8'hBC,
    parameter logic [7:0] SKP    = 8'h1C,
    parameter logic [7:0] STP    = 8'hFB,
    parameter logic [7:0] SDP    = 8'h5C,
    parameter logic [7:0] END_OK = 8'hFD,
    parameter logic [7:0] EDB    = 8'hFE,
    parameter logic [7:0] FTS    = 8'h3C,
    parameter logic [7:0] IDLE   = 8'h7C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enb,
    input  logic [7:0]  rx_multiplexada,
    input  logic        rx_ValidS,
    output logic [7:0]  rx_DataS,
    output logic        rx_data_valid,
    output logic [3:0]  symbol_code,
    output logic        locked,
    output logic        pkt_start,
    output logic        pkt_end,
    output logic        pkt_abort,
    output logic        err_framing,
    output logic [10:0] pkt_len,
    output logic [7:0]  skp_cnt,
    output logic [7:0]  err_cnt
);

    // Symbol classes reported on symbol_code
    localparam logic [3:0] c_code_data = 4'd0;
    localparam logic [3:0] c_code_com  = 4'd1;
    localparam logic [3:0] c_code_skp  = 4'd2;
    localparam logic [3:0] c_code_stp  = 4'd3;
    localparam logic [3:0] c_code_sdp  = 4'd4;
    localparam logic [3:0] c_code_end  = 4'd5;
    localparam logic [3:0] c_code_edb  = 4'd6;
    localparam logic [3:0] c_code_fts  = 4'd7;
    localparam logic [3:0] c_code_idle = 4'd8;
    localparam logic [3:0] c_code_unk  = 4'd15;

    // Framing state machine encoding
    localparam logic [1:0] c_st_unlocked = 2'd0;
    localparam logic [1:0] c_st_idle     = 2'd1;
    localparam logic [1:0] c_st_tlp      = 2'd2;
    localparam logic [1:0] c_st_dllp     = 2'd3;

    localparam logic [10:0] c_len_max = 11'd2047;
    localparam logic [7:0]  c_cnt_max = 8'd255;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_com_pend;
    logic [10:0] r_len;

    logic [7:0]  r_data;
    logic        r_data_valid;
    logic [3:0]  r_code;
    logic        r_pkt_start;
    logic        r_pkt_end;
    logic        r_pkt_abort;
    logic        r_err;
    logic [10:0] r_pkt_len;
    logic [7:0]  r_skp_cnt;
    logic [7:0]  r_err_cnt;

    logic [3:0]  w_code;
    logic        w_is_data;
    logic        w_in_pkt;
    logic        w_payload;
    logic        w_start;
    logic        w_end;
    logic        w_abort;
    logic        w_err;
    logic        w_len_clr;
    logic        w_com_pend_nxt;
    logic        w_skp;

    assign w_is_data = rx_ValidS;
    assign w_in_pkt  = (r_state == c_st_tlp) || (r_state == c_st_dllp);

    // ------------------------------------------------------------------
    // Byte classification
    // ------------------------------------------------------------------
    always_comb begin
        w_code = c_code_data;
        if (!rx_ValidS) begin
            if (rx_multiplexada == COM)         w_code = c_code_com;
            else if (rx_multiplexada == SKP)    w_code = c_code_skp;
            else if (rx_multiplexada == STP)    w_code = c_code_stp;
            else if (rx_multiplexada == SDP)    w_code = c_code_sdp;
            else if (rx_multiplexada == END_OK) w_code = c_code_end;
            else if (rx_multiplexada == EDB)    w_code = c_code_edb;
            else if (rx_multiplexada == FTS)    w_code = c_code_fts;
            else if (rx_multiplexada == IDLE)   w_code = c_code_idle;
            else                                w_code = c_code_unk;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_unlocked;
        end else if (enb) begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_unlocked: begin
                if (w_code == c_code_com) w_next_state = c_st_idle;
            end
            c_st_idle: begin
                if (w_code == c_code_stp)      w_next_state = c_st_tlp;
                else if (w_code == c_code_sdp) w_next_state = c_st_dllp;
            end
            default: begin
                if (!w_is_data) begin
                    // A COM inside a packet must be followed by SKP; any other
                    // control symbol breaks the ordered set and kills the packet,
                    // even a STP/SDP that would otherwise restart framing.
                    if (r_com_pend && (w_code != c_code_skp)) begin
                        w_next_state = c_st_idle;
                    end else begin
                        case (w_code)
                            c_code_com, c_code_skp: w_next_state = r_state;
                            c_code_stp:             w_next_state = c_st_tlp;
                            c_code_sdp:             w_next_state = c_st_dllp;
                            default:                w_next_state = c_st_idle;
                        endcase
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / event decode
    // ------------------------------------------------------------------
    always_comb begin
        w_payload      = 1'b0;
        w_start        = 1'b0;
        w_end          = 1'b0;
        w_abort        = 1'b0;
        w_err          = 1'b0;
        w_len_clr      = 1'b0;
        w_com_pend_nxt = r_com_pend;
        case (r_state)
            c_st_unlocked: begin
                w_com_pend_nxt = 1'b0;
            end
            c_st_idle: begin
                w_com_pend_nxt = 1'b0;
                if (w_is_data) begin
                    // Data-path IDLE bytes are line filler between packets
                    w_err = (rx_multiplexada != IDLE);
                end else begin
                    case (w_code)
                        c_code_stp, c_code_sdp: begin
                            w_start   = 1'b1;
                            w_len_clr = 1'b1;
                        end
                        c_code_com, c_code_skp, c_code_fts, c_code_idle: ;
                        default: w_err = 1'b1;
                    endcase
                end
            end
            default: begin
                w_com_pend_nxt = 1'b0;
                if (w_is_data) begin
                    w_payload = 1'b1;
                end else if (r_com_pend && (w_code != c_code_skp)) begin
                    w_err   = 1'b1;
                    w_abort = 1'b1;
                end else begin
                    case (w_code)
                        c_code_com: w_com_pend_nxt = 1'b1;
                        c_code_skp: ;
                        c_code_end: w_end = 1'b1;
                        c_code_edb: w_abort = 1'b1;
                        c_code_stp, c_code_sdp: begin
                            w_err     = 1'b1;
                            w_abort   = 1'b1;
                            w_start   = 1'b1;
                            w_len_clr = 1'b1;
                        end
                        default: begin
                            w_err   = 1'b1;
                            w_abort = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

    assign w_skp = (r_state != c_st_unlocked) && (w_code == c_code_skp);

    // ------------------------------------------------------------------
    // Datapath, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_com_pend   <= 1'b0;
            r_len        <= 11'd0;
            r_data       <= 8'd0;
            r_data_valid <= 1'b0;
            r_code       <= c_code_data;
            r_pkt_start  <= 1'b0;
            r_pkt_end    <= 1'b0;
            r_pkt_abort  <= 1'b0;
            r_err        <= 1'b0;
            r_pkt_len    <= 11'd0;
            r_skp_cnt    <= 8'd0;
            r_err_cnt    <= 8'd0;
        end else if (enb) begin
            r_com_pend   <= w_com_pend_nxt;
            r_code       <= w_code;
            r_data_valid <= w_payload;
            r_pkt_start  <= w_start;
            r_pkt_end    <= w_end;
            r_pkt_abort  <= w_abort;
            r_err        <= w_err;
            if (w_payload) begin
                r_data <= rx_multiplexada;
            end
            // Length of the finishing packet is captured before a restart
            // (STP/SDP mid-packet) clears the running count.
            if (w_end || w_abort) begin
                r_pkt_len <= r_len;
            end
            if (w_len_clr) begin
                r_len <= 11'd0;
            end else if (w_payload && (r_len != c_len_max)) begin
                r_len <= r_len + 11'd1;
            end
            if (w_skp && (r_skp_cnt != c_cnt_max)) begin
                r_skp_cnt <= r_skp_cnt + 8'd1;
            end
            if (w_err && (r_err_cnt != c_cnt_max)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end else begin
            r_data_valid <= 1'b0;
            r_pkt_start  <= 1'b0;
            r_pkt_end    <= 1'b0;
            r_pkt_abort  <= 1'b0;
            r_err        <= 1'b0;
        end
    end

    assign rx_DataS      = r_data;
    assign rx_data_valid = r_data_valid;
    assign symbol_code   = r_code;
    assign locked        = w_in_pkt || (r_state == c_st_idle);
    assign pkt_start     = r_pkt_start;
    assign pkt_end       = r_pkt_end;
    assign pkt_abort     = r_pkt_abort;
    assign err_framing   = r_err;
    assign pkt_len       = r_pkt_len;
    assign skp_cnt       = r_skp_cnt;
    assign err_cnt       = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rx_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_demux
// Description : Self-checking bench for rx_demux. Stimulus pushes the expected
//               output snapshot of each cycle into a queue; a monitor pops and
//               compares one snapshot per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_demux;

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] SKP    = 8'h1C;
    localparam logic [7:0] STP    = 8'hFB;
    localparam logic [7:0] SDP    = 8'h5C;
    localparam logic [7:0] END_OK = 8'hFD;
    localparam logic [7:0] EDB    = 8'hFE;
    localparam logic [7:0] FTS    = 8'h3C;
    localparam logic [7:0] IDLE   = 8'h7C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enb = 1'b0;
    logic [7:0]  rx_multiplexada = 8'd0;
    logic        rx_ValidS = 1'b0;
    logic [7:0]  rx_DataS;
    logic        rx_data_valid;
    logic [3:0]  symbol_code;
    logic        locked;
    logic        pkt_start;
    logic        pkt_end;
    logic        pkt_abort;
    logic        err_framing;
    logic [10:0] pkt_len;
    logic [7:0]  skp_cnt;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    rx_demux dut (
        .clk             (clk),
        .rst             (rst),
        .enb             (enb),
        .rx_multiplexada (rx_multiplexada),
        .rx_ValidS       (rx_ValidS),
        .rx_DataS        (rx_DataS),
        .rx_data_valid   (rx_data_valid),
        .symbol_code     (symbol_code),
        .locked          (locked),
        .pkt_start       (pkt_start),
        .pkt_end         (pkt_end),
        .pkt_abort       (pkt_abort),
        .err_framing     (err_framing),
        .pkt_len         (pkt_len),
        .skp_cnt         (skp_cnt),
        .err_cnt         (err_cnt)
    );

    typedef struct packed {
        logic [7:0]  data;
        logic        dv;
        logic [3:0]  code;
        logic        lk;
        logic        st;
        logic        en;
        logic        ab;
        logic        er;
        logic [10:0] len;
        logic [7:0]  skp;
        logic [7:0]  errc;
    } snap_t;

    snap_t q[$];
    snap_t m;          // expected outputs after the current byte
    int    m_mode;     // 0 unlocked, 1 between packets, 2 inside a packet
    int    m_count;    // payload bytes of current packet
    bit    m_com;      // COM seen inside a packet, waiting for SKP
    int    checks = 0;
    int    errors = 0;

    function automatic logic [3:0] classify(input logic v, input logic [7:0] b);
        if (v) return 4'd0;
        case (b)
            COM:     return 4'd1;
            SKP:     return 4'd2;
            STP:     return 4'd3;
            SDP:     return 4'd4;
            END_OK:  return 4'd5;
            EDB:     return 4'd6;
            FTS:     return 4'd7;
            IDLE:    return 4'd8;
            default: return 4'd15;
        endcase
    endfunction

    // Reference behaviour, written directly from the protocol rules
    task automatic model_step(input logic r, input logic e, input logic v, input logic [7:0] b);
        logic [3:0] c;
        m.dv = 0; m.st = 0; m.en = 0; m.ab = 0; m.er = 0;
        if (r) begin
            m = '0;
            m_mode = 0; m_count = 0; m_com = 0;
            return;
        end
        if (!e) return;
        c = classify(v, b);
        m.code = c;
        if (m_mode == 0) begin
            if (c == 4'd1) m_mode = 1;
        end else begin
            if (c == 4'd2 && m.skp != 8'd255) m.skp = m.skp + 8'd1;
            if (m_mode == 1) begin
                if (v) m.er = (b != IDLE);
                else if (c == 4'd3 || c == 4'd4) begin
                    m.st = 1; m_count = 0; m_mode = 2;
                end else if (!(c == 4'd1 || c == 4'd2 || c == 4'd7 || c == 4'd8)) m.er = 1;
            end else begin
                if (v) begin
                    m.dv = 1; m.data = b; m_com = 0;
                    if (m_count < 2047) m_count++;
                end else if (m_com && c != 4'd2) begin
                    m.er = 1; m.ab = 1; m.len = 11'(m_count); m_mode = 1; m_com = 0;
                end else begin
                    m_com = 0;
                    if (c == 4'd1) m_com = 1;
                    else if (c == 4'd2) ;
                    else if (c == 4'd5) begin m.en = 1; m.len = 11'(m_count); m_mode = 1; end
                    else if (c == 4'd6) begin m.ab = 1; m.len = 11'(m_count); m_mode = 1; end
                    else if (c == 4'd3 || c == 4'd4) begin
                        m.er = 1; m.ab = 1; m.st = 1; m.len = 11'(m_count); m_count = 0;
                    end else begin
                        m.er = 1; m.ab = 1; m.len = 11'(m_count); m_mode = 1;
                    end
                end
            end
            if (m.er && m.errc != 8'd255) m.errc = m.errc + 8'd1;
        end
        m.lk = (m_mode != 0);
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input logic [7:0] b);
        @(negedge clk);
        rst = r; enb = e; rx_ValidS = v; rx_multiplexada = b;
        model_step(r, e, v, b);
        q.push_back(m);
    endtask

    task automatic ctl(input logic [7:0] b); drive(1'b0, 1'b1, 1'b0, b); endtask
    task automatic dat(input logic [7:0] b); drive(1'b0, 1'b1, 1'b1, b); endtask

    // Monitor: one expected snapshot per clock once stimulus is running
    initial begin
        snap_t ex;
        snap_t got;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                ex  = q.pop_front();
                got = '{rx_DataS, rx_data_valid, symbol_code, locked, pkt_start,
                        pkt_end, pkt_abort, err_framing, pkt_len, skp_cnt, err_cnt};
                checks++;
                if (got !== ex) begin
                    errors++;
                    $display("FAIL outputs t=%0t got data=%h dv=%b code=%0d lk=%b st=%b end=%b ab=%b err=%b len=%0d skp=%0d errc=%0d | exp data=%h dv=%b code=%0d lk=%b st=%b end=%b ab=%b err=%b len=%0d skp=%0d errc=%0d",
                             $time, got.data, got.dv, got.code, got.lk, got.st, got.en, got.ab, got.er,
                             got.len, got.skp, got.errc, ex.data, ex.dv, ex.code, ex.lk, ex.st, ex.en,
                             ex.ab, ex.er, ex.len, ex.skp, ex.errc);
                end
            end
        end
    end

    logic [7:0] syms [9];

    initial begin
        int   r;
        int   k;
        logic [7:0] b;
        syms[0] = COM; syms[1] = SKP; syms[2] = STP; syms[3] = SDP; syms[4] = END_OK;
        syms[5] = EDB; syms[6] = FTS; syms[7] = IDLE; syms[8] = 8'h00;

        // Reset state
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 1'b0, COM);   // reset wins over enable
        // Pre-lock bytes ignored, then lock
        dat(8'h55); ctl(STP); ctl(END_OK); ctl(SKP); ctl(COM);
        // Basic TLP
        ctl(STP); dat(8'h11); dat(8'h22); dat(8'h33); ctl(END_OK);
        // Skip ordered set inside a packet
        ctl(STP); dat(8'hAA); ctl(COM); ctl(SKP); ctl(SKP); dat(8'hBB); ctl(END_OK);
        // DLLP ending bad
        ctl(SDP); dat(8'h01); ctl(EDB);
        // Idle filler then a stray data byte
        repeat (4) dat(IDLE);
        dat(8'h42);
        // Restart mid-packet, then reset mid-packet
        ctl(STP); dat(8'h10); ctl(STP); dat(8'h20); ctl(END_OK);
        ctl(SDP); dat(8'h30);
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, COM);
        // Enable low mid-packet freezes everything
        ctl(STP); dat(8'h61);
        drive(1'b0, 1'b0, 1'b1, 8'h99);
        drive(1'b0, 1'b0, 1'b0, END_OK);
        dat(8'h62); ctl(END_OK);
        // COM followed by a non-SKP control inside a packet
        ctl(STP); dat(8'h01); ctl(COM); ctl(STP);
        ctl(SDP); ctl(FTS); ctl(STP); ctl(8'h00); ctl(SDP); ctl(IDLE);
        // Length saturation
        ctl(STP);
        for (int i = 0; i < 2060; i++) dat(8'(i));
        ctl(END_OK);
        // Counter saturation
        repeat (270) ctl(SKP);
        repeat (270) dat(8'h42);
        // Randomized traffic
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 199));
            k = int'($urandom_range(0, 9));
            if (k < 4) begin
                b = ($urandom_range(0, 3) == 0) ? IDLE : 8'($urandom);
                drive(r == 0, !(r >= 1 && r <= 12), 1'b1, b);
            end else begin
                b = syms[$urandom_range(0, 8)];
                if (b == 8'h00) b = 8'($urandom);
                drive(r == 0, !(r >= 1 && r <= 12), 1'b0, b);
            end
        end

        // Every expected snapshot must be consumed within a bounded time
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
